// File: rtl/pof_shift_pkg.sv
// Shared definitions for the shift-code producers and consumers of the shift LUT:
// code width, the right-shift-by-one code and a reference leading-zero counter.
package pof_shift_pkg;

  localparam int SHIFT_W = 6;

  typedef logic signed [SHIFT_W-1:0] shift_code_t;

  localparam shift_code_t SHIFT_RIGHT1 = 6'h3F;

  // Leading zeros of the low w bits of v; returns w when they are all zero.
  function automatic logic [SHIFT_W-1:0] lzc(input logic [31:0] v, input int w);
    logic [SHIFT_W-1:0] n;
    n = SHIFT_W'(w);
    for (int i = 0; i < 32; i++) begin
      if (i < w && v[i]) begin
        n = SHIFT_W'(w - 1 - i);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/signed_shift_encoder_if.sv
// Input and output stream of the normaliser bundled as one interface;
// slave is the encoder's view, master the producer/consumer view.
interface signed_shift_encoder_if
  import pof_shift_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int EXP_W  = 9
);
  logic               s_valid;
  logic               s_ready;
  logic               s_carry;
  logic [DATA_W-1:0]  s_data;
  logic [EXP_W-1:0]   s_exp;
  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic [EXP_W-1:0]   m_exp;
  logic [SHIFT_W-1:0] m_shift;
  logic               m_sticky;
  logic               m_zero;

  modport slave (
    input  s_valid, s_carry, s_data, s_exp, m_ready,
    output s_ready, m_valid, m_data, m_exp, m_shift, m_sticky, m_zero
  );

  modport master (
    output s_valid, s_carry, s_data, s_exp, m_ready,
    input  s_ready, m_valid, m_data, m_exp, m_shift, m_sticky, m_zero
  );
endinterface

// File: rtl/lzc_priority.sv
// Combinational leading-zero counter: count of zeros above the first set bit,
// plus a flag for an all-zero word.
module lzc_priority
  import pof_shift_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [DATA_W-1:0]  data,
  output logic [SHIFT_W-1:0] count,
  output logic               all_zero
);

  assign count    = lzc(32'(data), DATA_W);
  assign all_zero = ~|data;

endmodule

// File: rtl/signed_shift_encoder.sv
// Two-stage normaliser: S1 finds the shift code, S2 applies it to the mantissa
// and exponent. Both stages use valid/ready with a combinational ready chain.
module signed_shift_encoder
  import pof_shift_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int EXP_W  = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  signed_shift_encoder_if.slave  bus
);

  logic               v1_reg;
  logic               c1_reg;
  logic [DATA_W-1:0]  d1_reg;
  logic [EXP_W-1:0]   e1_reg;
  shift_code_t        sh1_reg;
  logic               st1_reg;
  logic               z1_reg;

  logic               v2_reg;
  logic [DATA_W-1:0]  d2_reg;
  logic [EXP_W-1:0]   e2_reg;
  shift_code_t        sh2_reg;
  logic               st2_reg;
  logic               z2_reg;

  logic               ready1;
  logic               ready2;

  logic [SHIFT_W-1:0] lz_count;
  logic               lz_zero;
  shift_code_t        sh1_next;
  logic               st1_next;
  logic               z1_next;
  logic [DATA_W-1:0]  d2_next;
  logic [EXP_W-1:0]   e2_next;

  assign ready2 = !v2_reg || bus.m_ready;
  assign ready1 = !v1_reg || ready2;

  lzc_priority #(.DATA_W(DATA_W)) u_lzc (
    .data     (bus.s_data),
    .count    (lz_count),
    .all_zero (lz_zero)
  );

  // Carry beats always shift right by one, whatever the mantissa holds.
  always_comb begin
    sh1_next = '0;
    st1_next = 1'b0;
    z1_next  = 1'b0;
    if (bus.s_carry) begin
      sh1_next = SHIFT_RIGHT1;
      st1_next = bus.s_data[0];
    end else if (!lz_zero) begin
      sh1_next = shift_code_t'(lz_count);
    end else begin
      z1_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg  <= 1'b0;
      c1_reg  <= 1'b0;
      d1_reg  <= '0;
      e1_reg  <= '0;
      sh1_reg <= '0;
      st1_reg <= 1'b0;
      z1_reg  <= 1'b0;
    end else if (ready1) begin
      v1_reg <= bus.s_valid;
      if (bus.s_valid) begin
        c1_reg  <= bus.s_carry;
        d1_reg  <= bus.s_data;
        e1_reg  <= bus.s_exp;
        sh1_reg <= sh1_next;
        st1_reg <= st1_next;
        z1_reg  <= z1_next;
      end
    end
  end

  // Exponent moves opposite to the shift; subtracting the sign-extended
  // code makes the right shift an increment. Wraps by design.
  always_comb begin
    d2_next = '0;
    e2_next = e1_reg - EXP_W'(sh1_reg);
    if (z1_reg) begin
      d2_next = '0;
    end else if (sh1_reg == SHIFT_RIGHT1) begin
      d2_next = {c1_reg, d1_reg[DATA_W-1:1]};
    end else begin
      d2_next = d1_reg << unsigned'(sh1_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_reg  <= 1'b0;
      d2_reg  <= '0;
      e2_reg  <= '0;
      sh2_reg <= '0;
      st2_reg <= 1'b0;
      z2_reg  <= 1'b0;
    end else if (ready2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        d2_reg  <= d2_next;
        e2_reg  <= e2_next;
        sh2_reg <= sh1_reg;
        st2_reg <= st1_reg;
        z2_reg  <= z1_reg;
      end
    end
  end

  assign bus.s_ready  = ready1;
  assign bus.m_valid  = v2_reg;
  assign bus.m_data   = d2_reg;
  assign bus.m_exp    = e2_reg;
  assign bus.m_shift  = sh2_reg;
  assign bus.m_sticky = st2_reg;
  assign bus.m_zero   = z2_reg;

endmodule

// File: tb/tb_signed_shift_encoder.sv
// Bench for signed_shift_encoder: directed corner beats, then randomized
// streams with back-pressure checked against a value-level reference model.
module tb_signed_shift_encoder;
  import pof_shift_pkg::*;

  localparam int DW = 24;
  localparam int EW = 9;

  logic clk = 1'b0;
  logic rst;

  signed_shift_encoder_if #(.DATA_W(DW), .EXP_W(EW)) bus ();

  signed_shift_encoder #(.DATA_W(DW), .EXP_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic [5:0]    sh;
    logic          st;
    logic          z;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Normalise by repeated doubling until the top bit is set; the shift
  // count is simply how many doublings it took.
  function automatic beat_t ref_model(input bit c, input logic [DW-1:0] d, input logic [EW-1:0] e);
    beat_t         r;
    logic [DW-1:0] v;
    logic [DW:0]   wide;
    int            n;
    r.st = 1'b0;
    r.z  = 1'b0;
    if (c) begin
      wide = {1'b1, d};
      r.d  = DW'(wide >> 1);
      r.sh = 6'h3F;
      r.e  = e + EW'(1);
      r.st = d[0];
    end else if (d == '0) begin
      r.d  = '0;
      r.sh = '0;
      r.e  = e;
      r.z  = 1'b1;
    end else begin
      v = d;
      n = 0;
      while (v[DW-1] == 1'b0) begin
        v = v << 1;
        n++;
      end
      r.d  = v;
      r.sh = 6'(n);
      r.e  = e - EW'(n);
    end
    return r;
  endfunction

  task automatic compare_beat(input string tag, input beat_t w);
    check_val({tag, "_data"},   bus.m_data,   w.d);
    check_val({tag, "_exp"},    bus.m_exp,    w.e);
    check_val({tag, "_shift"},  bus.m_shift,  w.sh);
    check_val({tag, "_sticky"}, bus.m_sticky, w.st);
    check_val({tag, "_zero"},   bus.m_zero,   w.z);
  endtask

  task automatic directed(input string tag, input bit c, input logic [DW-1:0] d, input logic [EW-1:0] e,
                          input logic [DW-1:0] xd, input logic [EW-1:0] xe, input logic [5:0] xs,
                          input bit xst, input bit xz);
    beat_t w;
    w.d = xd; w.e = xe; w.sh = xs; w.st = xst; w.z = xz;
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_carry = c;
    bus.s_data  = d;
    bus.s_exp   = e;
    #1 check_val({tag, "_s_ready"}, bus.s_ready, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_val({tag, "_lat1_valid"}, bus.m_valid, 0);
    @(negedge clk);
    check_val({tag, "_lat2_valid"}, bus.m_valid, 1);
    compare_beat(tag, w);
    $display("directed %s: in c=%0b d=0x%06h e=%0d -> data=0x%06h exp=0x%03h shift=0x%02h sticky=%0b zero=%0b",
             tag, c, d, $signed(e), bus.m_data, bus.m_exp, bus.m_shift, bus.m_sticky, bus.m_zero);
  endtask

  task automatic stream(input string tag, input int ncyc, input bit pattern, input int max_beats);
    beat_t w;
    beat_t held;
    bit    hold = 1'b0;
    int    sent = 0;
    bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (hold) begin
        check_val({tag, "_stall_valid"}, bus.m_valid, 1);
        compare_beat({tag, "_stall"}, held);
      end
      bus.m_ready = pattern ? pat[i % 4] : ($urandom_range(0, 3) != 0);
      bus.s_valid = (sent < max_beats) && (pattern || ($urandom_range(0, 2) != 0));
      bus.s_carry = ($urandom_range(0, 3) == 0);
      bus.s_data  = DW'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) bus.s_data = '0;
      bus.s_exp   = EW'($urandom);
      #1;
      check_val({tag, "_s_ready"}, bus.s_ready, !(exp_q.size() == 2 && !bus.m_ready));
      hold = 1'b0;
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          check_val({tag, "_spurious_valid"}, bus.m_valid, 0);
        end else if (bus.m_ready) begin
          w = exp_q.pop_front();
          compare_beat(tag, w);
          $display("%s beat: data=0x%06h exp=0x%03h shift=0x%02h sticky=%0b zero=%0b",
                   tag, bus.m_data, bus.m_exp, bus.m_shift, bus.m_sticky, bus.m_zero);
        end else begin
          hold    = 1'b1;
          held.d  = bus.m_data;
          held.e  = bus.m_exp;
          held.sh = bus.m_shift;
          held.st = bus.m_sticky;
          held.z  = bus.m_zero;
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(ref_model(bus.s_carry, bus.s_data, bus.s_exp));
        sent++;
      end
    end
    bus.s_valid = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1;
      if (bus.m_valid) begin
        w = exp_q.pop_front();
        compare_beat({tag, "_drain"}, w);
        $display("%s drain beat: data=0x%06h exp=0x%03h shift=0x%02h", tag, bus.m_data, bus.m_exp, bus.m_shift);
      end
    end
    check_val({tag, "_drain_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_carry = 1'b0;
    bus.s_data  = '0;
    bus.s_exp   = '0;
    bus.m_ready = 1'b0;
    #1;
    check_val("rst_m_valid",  bus.m_valid,  0);
    check_val("rst_m_data",   bus.m_data,   0);
    check_val("rst_m_exp",    bus.m_exp,    0);
    check_val("rst_m_shift",  bus.m_shift,  0);
    check_val("rst_m_sticky", bus.m_sticky, 0);
    check_val("rst_m_zero",   bus.m_zero,   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_s_ready", bus.s_ready, 1);

    directed("lz23",  1'b0, 24'h000001, 9'd10,  24'h800000, 9'h1F3, 6'd23,  1'b0, 1'b0);
    directed("carry", 1'b1, 24'h000003, 9'd5,   24'h800001, 9'd6,   6'h3F,  1'b1, 1'b0);
    directed("zero",  1'b0, 24'h000000, 9'd7,   24'h000000, 9'd7,   6'd0,   1'b0, 1'b1);
    directed("norm",  1'b0, 24'h800000, 9'h100, 24'h800000, 9'h100, 6'd0,   1'b0, 1'b0);
    directed("wrap",  1'b1, 24'h000000, 9'd255, 24'h800000, 9'h100, 6'h3F,  1'b0, 1'b0);

    stream("toggle", 40, 1'b1, 8);
    stream("rand", 400, 1'b0, 1000);

    // Fill both stages, then reset in the middle of a cycle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_carry = 1'b0;
      bus.s_data  = DW'($urandom) | 24'h000100;
      bus.s_exp   = EW'($urandom);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    check_val("full_s_ready", bus.s_ready, 0);
    check_val("full_m_valid", bus.m_valid, 1);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_m_valid", bus.m_valid, 0);
    check_val("async_rst_m_data",  bus.m_data,  0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_val("after_rst_m_valid", bus.m_valid, 0);
      check_val("after_rst_s_ready", bus.s_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
